lsu_access_sequencer: RTL and testbench
=======================================

// Module: lsu_access_sequencer
// PURPOSE
//  Load/store sequencer between the execute stage and data memory. Accepts one load/store
//  per handshake, checks funct3 and address range, and drives the memory's we/address/
//  data/funct3 ports. Aligned accesses go out as one memory cycle. Misaligned accesses
//  are split into byte accesses, reassembled and extended. Returns a one-cycle response pulse.
// PARAMETERS
//  MEM_BYTES         1024  bytes of data memory; any accessed byte >= MEM_BYTES is an error
//  ALLOW_MISALIGNED  1     1: split misaligned accesses into bytes; 0: misaligned -> error
// PORTS
//  clk_i           in   1   clock, all state on rising edge
//  rst_i           in   1   reset, asynchronous, active-high
//  req_valid_i     in   1   request present
//  req_ready_o     out  1   sequencer can accept (IDLE only)
//  req_write_i     in   1   1 = store, 0 = load
//  req_funct3_i    in   3   RISC-V load/store funct3
//  req_addr_i      in   32  byte address
//  req_wdata_i     in   32  store data (LSBs significant for SB/SH)
//  resp_valid_o    out  1   one-cycle response pulse
//  resp_err_o      out  1   qualifies resp_valid_o: illegal funct3, out of range, or disallowed misalign
//  resp_rdata_o    out  32  load result, extended per funct3; 0 for stores and errors
//  mem_we_o        out  1   memory write enable
//  mem_addr_o      out  32  memory byte address
//  mem_wdata_o     out  32  memory write data
//  mem_funct3_o    out  3   memory access width code
//  mem_rdata_i     in   32  memory read data, combinational from mem_addr_o/mem_funct3_o
// BEHAVIOUR
//  Reset values: req_ready_o=1; resp_valid_o=0, resp_err_o=0, resp_rdata_o=0; mem_we_o=0,
//   mem_addr_o=0, mem_wdata_o=0, mem_funct3_o=3'b100. These idle values also apply whenever
//   the sequencer is not issuing.
//  States: IDLE, ISSUE, SPLIT, RESP.
//  IDLE: accept when req_valid_i & req_ready_o. Latch write, funct3, address and wdata.
//   Legal funct3: loads 000/001/010/100/101; stores 000/001/010. Any other code -> error.
//   Size is 1/2/4 bytes. Misaligned means addr[0]=1 for half, or addr[1:0]!=0 for word.
//   Error if funct3 is illegal, if addr+size-1 >= MEM_BYTES (32-bit unsigned, no wrap), or if
//   misaligned with ALLOW_MISALIGNED=0. On error go to RESP with err set; no memory cycle.
//   Otherwise: aligned -> ISSUE; misaligned -> SPLIT with byte_idx=0.
//  ISSUE (1 cycle): mem_addr_o=addr, mem_funct3_o=funct3, mem_wdata_o=wdata, mem_we_o=write.
//   For loads, capture mem_rdata_i at the clock edge. Next state RESP.
//  SPLIT (size cycles): mem_addr_o=addr+byte_idx.
//   Store: mem_funct3_o=000, mem_we_o=1, mem_wdata_o={24'b0, wdata byte byte_idx}.
//   Load: mem_funct3_o=100, mem_we_o=0, capture mem_rdata_i[7:0] into result byte byte_idx.
//   byte_idx increments each cycle; after byte size-1, go to RESP.
//  RESP (1 cycle): resp_valid_o=1; req_ready_o=0. Split-load result is extended per funct3:
//   000 sign-8, 001 sign-16, 100 zero-8, 101 zero-16, 010 none. Next state IDLE.
//  Latency from accept edge T: error -> resp at T+1; aligned -> resp at T+2;
//   misaligned -> resp at T+size+1. The next request is accepted at the earliest in the
//   cycle after the resp pulse.
//  No response backpressure: the pipeline must stall on req_ready_o.
//  Reset mid-operation: all outputs return to reset values immediately. Already-written
//   split bytes are not rolled back, and no response is issued for the aborted request.
// TESTING
//  1 Preload bytes 4..7=16,34,91,88. LW addr 4 -> one ISSUE (addr 4, f3 010);
//    resp at T+2 with rdata 0x88913416, err=0.
//  2 Same memory. LH addr 5 -> SPLIT reads addr 5 then 6 (f3 100); resp at T+3 with
//    rdata 0xFFFF9134. LHU addr 5 -> 0x00009134.
//  3 SW 0xAABBCCDD at 0x101 -> four SB at 0x101..0x104 with wdata DD,CC,BB,AA; then LW 0x101 -> 0xAABBCCDD at T+5.
//  4 funct3 011 load, SB with funct3 100, LW at 1022 -> each gives resp at T+1 with err=1,
//    rdata 0, and mem_we_o=0 throughout.
//  5 ALLOW_MISALIGNED=0: LW at 2 -> err at T+1. SW at 8 -> one ISSUE with we=1, resp at T+2.
//  6 Assert rst_i mid-SPLIT of SW at 0x21 after 2 bytes -> mem_we_o drops the same cycle,
//    no resp; req_ready_o=1 after release; bytes 0x21-0x22 written, 0x23-0x24 unchanged.

Source files
------------

// File: rtl/lsu_access_sequencer.sv
// lsu_access_sequencer: issues loads/stores to data memory; misaligned accesses are split into byte cycles.
module lsu_access_sequencer #(
  parameter int MEM_BYTES        = 1024,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic        resp_err_o,
  output logic [31:0] resp_rdata_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [2:0]  mem_funct3_o,
  input  logic [31:0] mem_rdata_i
);
  typedef enum logic [1:0] {IDLE, ISSUE, SPLIT, RESP} state_t;
  state_t      state, state_n;
  logic        write_q, err_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, rdata_q, wshift;
  logic [1:0]  idx_q, idx_last;
  logic        accept, legal, mis, oor, err;
  logic [2:0]  size;
  logic [32:0] last;

  function automatic logic [31:0] ext(input logic [2:0] f, input logic [31:0] d);
    return f == 3'b000 ? {{24{d[7]}}, d[7:0]} :
           f == 3'b001 ? {{16{d[15]}}, d[15:0]} :
           f == 3'b100 ? {24'b0, d[7:0]} :
           f == 3'b101 ? {16'b0, d[15:0]} : d;
  endfunction

  assign accept = req_valid_i & req_ready_o;
  assign legal  = req_write_i ? (req_funct3_i == 3'b000 || req_funct3_i == 3'b001 || req_funct3_i == 3'b010)
                              : (req_funct3_i == 3'b000 || req_funct3_i == 3'b001 || req_funct3_i == 3'b010 ||
                                 req_funct3_i == 3'b100 || req_funct3_i == 3'b101);
  assign size   = req_funct3_i[1] ? 3'd4 : req_funct3_i[0] ? 3'd2 : 3'd1;
  assign mis    = (req_funct3_i[1:0] == 2'b01 && req_addr_i[0]) || (req_funct3_i[1:0] == 2'b10 && req_addr_i[1:0] != 2'b00);
  // 33-bit sum so an address near 2^32 cannot wrap into range
  assign last   = {1'b0, req_addr_i} + 33'(size) - 33'd1;
  assign oor    = last >= 33'(MEM_BYTES);
  assign err    = !legal || oor || (mis && !ALLOW_MISALIGNED);
  assign idx_last = {f3_q[1], f3_q[1] | f3_q[0]};
  assign wshift = wdata_q >> {idx_q, 3'b000};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'b0;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      rdata_q <= 32'b0;
      idx_q   <= 2'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && accept) begin
        write_q <= req_write_i;
        err_q   <= err;
        f3_q    <= req_funct3_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        rdata_q <= 32'b0;
        idx_q   <= 2'b0;
      end
      if (state == ISSUE && !write_q) rdata_q <= mem_rdata_i;
      if (state == SPLIT) begin
        if (!write_q) rdata_q[{idx_q, 3'b000} +: 8] <= mem_rdata_i[7:0];
        idx_q <= idx_q + 2'd1;
      end
    end
  end

  always_comb begin
    state_n      = state == IDLE  ? (accept ? (err ? RESP : mis ? SPLIT : ISSUE) : IDLE) :
                   state == ISSUE ? RESP :
                   state == SPLIT ? (idx_q == idx_last ? RESP : SPLIT) : IDLE;
    req_ready_o  = state == IDLE;
    resp_valid_o = state == RESP;
    resp_err_o   = state == RESP && err_q;
    resp_rdata_o = (state == RESP && !write_q && !err_q) ? ext(f3_q, rdata_q) : 32'b0;
    mem_we_o     = (state == ISSUE || state == SPLIT) && write_q;
    mem_addr_o   = state == ISSUE ? addr_q : state == SPLIT ? addr_q + {30'b0, idx_q} : 32'b0;
    mem_funct3_o = state == ISSUE ? f3_q : (state == SPLIT && write_q) ? 3'b000 : 3'b100;
    mem_wdata_o  = state == ISSUE ? wdata_q : state == SPLIT ? {24'b0, wshift[7:0]} : 32'b0;
  end
endmodule

// File: tb/tb_lsu_access_sequencer.sv
// tb_lsu_access_sequencer: directed checks of both misalignment modes against byte-array memories.
module tb_lsu_access_sequencer;
  logic        clk = 1'b0, rst = 1'b1;
  logic        valid = 1'b0, write = 1'b0;
  logic [2:0]  f3 = 3'b0;
  logic [31:0] addr = 32'b0, wdata = 32'b0;
  logic [1:0]  rdy, rv, re, we;
  logic [31:0] rdat [2], maddr [2], mwd [2], mrd [2];
  logic [2:0]  mf3 [2];
  int          n_chk = 0, n_pass = 0;
  int          lat, n_tr;
  logic        r_err, saw_we;
  logic [31:0] r_data;
  logic [31:0] tr_addr [8], tr_wd [8];
  logic [2:0]  tr_f3 [8];
  logic [7:0]  pre23, pre24;

  always #5 clk = ~clk;

  function automatic logic [31:0] rdm(input logic [2:0] f, input logic [7:0] b0, b1, b2, b3);
    case (f)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b100:  return {24'b0, b0};
      3'b101:  return {16'b0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_mem
    logic [7:0] m [1024];
    logic [9:0] a;
    assign a = maddr[g][9:0];
    assign mrd[g] = rdm(mf3[g], m[a], m[a + 10'd1], m[a + 10'd2], m[a + 10'd3]);
    always @(posedge clk)
      if (we[g]) begin
        m[a] <= mwd[g][7:0];
        if (mf3[g][1:0] != 2'b00) m[a + 10'd1] <= mwd[g][15:8];
        if (mf3[g][1]) begin
          m[a + 10'd2] <= mwd[g][23:16];
          m[a + 10'd3] <= mwd[g][31:24];
        end
      end
  end

  lsu_access_sequencer #(.MEM_BYTES(1024), .ALLOW_MISALIGNED(1'b1)) dut0 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_ready_o(rdy[0]), .req_write_i(write),
    .req_funct3_i(f3), .req_addr_i(addr), .req_wdata_i(wdata), .resp_valid_o(rv[0]),
    .resp_err_o(re[0]), .resp_rdata_o(rdat[0]), .mem_we_o(we[0]), .mem_addr_o(maddr[0]),
    .mem_wdata_o(mwd[0]), .mem_funct3_o(mf3[0]), .mem_rdata_i(mrd[0]));

  lsu_access_sequencer #(.MEM_BYTES(1024), .ALLOW_MISALIGNED(1'b0)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_ready_o(rdy[1]), .req_write_i(write),
    .req_funct3_i(f3), .req_addr_i(addr), .req_wdata_i(wdata), .resp_valid_o(rv[1]),
    .resp_err_o(re[1]), .resp_rdata_o(rdat[1]), .mem_we_o(we[1]), .mem_addr_o(maddr[1]),
    .mem_wdata_o(mwd[1]), .mem_funct3_o(mf3[1]), .mem_rdata_i(mrd[1]));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, act, exp);
  endtask

  // Issue one request at a negedge; record the memory trace until the response on DUT s.
  task automatic do_req(input int s, input logic w, input logic [2:0] fn, input logic [31:0] a, input logic [31:0] d);
    int t = 0;
    while (!(rdy[0] && rdy[1]) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("ready_timeout", 32'd0, 32'd1);
    valid = 1'b1; write = w; f3 = fn; addr = a; wdata = d;
    @(posedge clk);
    #1 valid = 1'b0;
    lat = 0; n_tr = 0; saw_we = 1'b0; r_err = 1'b0; r_data = 32'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (rv[s]) begin
        lat = n; r_err = re[s]; r_data = rdat[s];
        break;
      end
      if (we[s]) saw_we = 1'b1;
      if (n_tr < 8) begin
        tr_addr[n_tr] = maddr[s]; tr_wd[n_tr] = mwd[s]; tr_f3[n_tr] = mf3[s];
      end
      n_tr++;
    end
    if (lat == 0) check("resp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(rdy[0]), 32'd1);
    check("rst_resp_valid", 32'(rv[0]), 32'd0);
    check("rst_we", 32'(we[0]), 32'd0);
    check("rst_addr", maddr[0], 32'd0);
    check("rst_wdata", mwd[0], 32'd0);
    check("rst_f3", 32'(mf3[0]), 32'd4);
    check("rst_rdata", rdat[0], 32'd0);
    rst = 1'b0;
    @(negedge clk);
    // preload bytes 4..7 with an aligned word store
    do_req(0, 1'b1, 3'b010, 32'd4, 32'h8891_3416);
    check("pre_sw_lat", 32'(lat), 32'd2);
    check("pre_sw_err", 32'(r_err), 32'd0);
    check("pre_sw_rdata", r_data, 32'd0);
    check("pre_mem7", 32'(g_mem[0].m[7]), 32'h88);
    do_req(0, 1'b0, 3'b010, 32'd4, 32'd0);
    check("lw_lat", 32'(lat), 32'd2);
    check("lw_rdata", r_data, 32'h8891_3416);
    check("lw_err", 32'(r_err), 32'd0);
    check("lw_ntr", 32'(n_tr), 32'd1);
    check("lw_addr", tr_addr[0], 32'd4);
    check("lw_f3", 32'(tr_f3[0]), 32'd2);
    check("resp_ready_low", 32'(rdy[0]), 32'd0);
    do_req(0, 1'b0, 3'b001, 32'd5, 32'd0);
    check("lh_lat", 32'(lat), 32'd3);
    check("lh_rdata", r_data, 32'hFFFF_9134);
    check("lh_addr0", tr_addr[0], 32'd5);
    check("lh_addr1", tr_addr[1], 32'd6);
    check("lh_f3", 32'(tr_f3[1]), 32'd4);
    do_req(0, 1'b0, 3'b101, 32'd5, 32'd0);
    check("lhu_rdata", r_data, 32'h0000_9134);
    do_req(0, 1'b0, 3'b000, 32'd7, 32'd0);
    check("lb_rdata", r_data, 32'hFFFF_FF88);
    do_req(0, 1'b1, 3'b010, 32'h101, 32'hAABB_CCDD);
    check("sw_split_lat", 32'(lat), 32'd5);
    check("sw_split_ntr", 32'(n_tr), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("sw_split_addr", tr_addr[i], 32'h101 + 32'(i));
      check("sw_split_f3", 32'(tr_f3[i]), 32'd0);
    end
    check("sw_split_wd0", tr_wd[0], 32'hDD);
    check("sw_split_wd1", tr_wd[1], 32'hCC);
    check("sw_split_wd2", tr_wd[2], 32'hBB);
    check("sw_split_wd3", tr_wd[3], 32'hAA);
    do_req(0, 1'b0, 3'b010, 32'h101, 32'd0);
    check("lw_split_lat", 32'(lat), 32'd5);
    check("lw_split_rdata", r_data, 32'hAABB_CCDD);
    do_req(0, 1'b0, 3'b011, 32'd8, 32'd0);
    check("bad_f3_lat", 32'(lat), 32'd1);
    check("bad_f3_err", 32'(r_err), 32'd1);
    check("bad_f3_rdata", r_data, 32'd0);
    check("bad_f3_we", 32'(saw_we), 32'd0);
    do_req(0, 1'b1, 3'b100, 32'd8, 32'h55);
    check("sb_f3_100_lat", 32'(lat), 32'd1);
    check("sb_f3_100_err", 32'(r_err), 32'd1);
    check("sb_f3_100_we", 32'(saw_we), 32'd0);
    do_req(0, 1'b0, 3'b010, 32'd1022, 32'd0);
    check("oor_lat", 32'(lat), 32'd1);
    check("oor_err", 32'(r_err), 32'd1);
    check("oor_rdata", r_data, 32'd0);
    check("oor_we", 32'(saw_we), 32'd0);
    do_req(0, 1'b0, 3'b010, 32'd1020, 32'd0);
    check("edge_lat", 32'(lat), 32'd2);
    check("edge_err", 32'(r_err), 32'd0);
    do_req(0, 1'b0, 3'b010, 32'hFFFF_FFFE, 32'd0);
    check("wrap_err", 32'(r_err), 32'd1);
    do_req(1, 1'b0, 3'b010, 32'd2, 32'd0);
    check("nomis_lat", 32'(lat), 32'd1);
    check("nomis_err", 32'(r_err), 32'd1);
    do_req(1, 1'b1, 3'b010, 32'd8, 32'h1234_5678);
    check("nomis_sw_lat", 32'(lat), 32'd2);
    check("nomis_sw_ntr", 32'(n_tr), 32'd1);
    check("nomis_sw_we", 32'(saw_we), 32'd1);
    check("nomis_sw_addr", tr_addr[0], 32'd8);
    check("nomis_sw_mem", 32'(g_mem[1].m[11]), 32'h12);
    // abort a split store after two bytes
    while (!(rdy[0] && rdy[1])) @(negedge clk);
    pre23 = g_mem[0].m[35]; pre24 = g_mem[0].m[36];
    valid = 1'b1; write = 1'b1; f3 = 3'b010; addr = 32'h21; wdata = 32'h1122_3344;
    @(posedge clk);
    #1 valid = 1'b0;
    @(negedge clk);
    check("abort_b0_addr", maddr[0], 32'h21);
    check("abort_b0_we", 32'(we[0]), 32'd1);
    @(negedge clk);
    check("abort_b1_addr", maddr[0], 32'h22);
    check("abort_b1_wd", mwd[0], 32'h33);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check("abort_we_drop", 32'(we[0]), 32'd0);
    check("abort_no_resp", 32'(rv[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(rdy[0]), 32'd1);
    check("abort_no_resp2", 32'(rv[0]), 32'd0);
    check("abort_m21", 32'(g_mem[0].m[33]), 32'h44);
    check("abort_m22", 32'(g_mem[0].m[34]), 32'h33);
    check("abort_m23", 32'(g_mem[0].m[35]), 32'(pre23));
    check("abort_m24", 32'(g_mem[0].m[36]), 32'(pre24));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
